// File: rtl/uart_rx_pkg.sv
// UART Rx byte controller shared types: state encoding, widths, defaults.
// Imported by uart_rx_byte_ctrl and its interface.
package uart_rx_pkg;

    localparam int STATE_W = 3;
    localparam int CNT_W = 4;
    localparam int DEF_DATA_BITS = 8;
    localparam int DEF_GAP_BITS = 20;

    typedef enum logic [STATE_W-1:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_byte_ctrl_if.sv
// Output byte buffer handshake between the Rx controller and the Rx FIFO.
// master: controller (drives byte, valid, errors); slave: consumer (drives ready).
interface uart_rx_byte_ctrl_if;

    logic [7:0] Byte_o;
    logic       ByteValid_o;
    logic       ByteReady_i;
    logic       ParityErr_o;
    logic       FrameErr_o;

    modport master (
        output Byte_o,
        output ByteValid_o,
        output ParityErr_o,
        output FrameErr_o,
        input  ByteReady_i
    );

    modport slave (
        input  Byte_o,
        input  ByteValid_o,
        input  ParityErr_o,
        input  FrameErr_o,
        output ByteReady_i
    );

endinterface

// File: rtl/tmr_voter.sv
// Bitwise 2-of-3 majority voter with a disagreement flag.
// Ports: a/b/c replicas in, y voted value, err high when any replica differs.
module tmr_voter #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] y,
    output logic         err
);

    assign y   = (a & b) | (a & c) | (b & c);
    assign err = |((a ^ y) | (b ^ y) | (c ^ y));

endmodule

// File: rtl/uart_rx_byte_ctrl.sv
// UART Rx sequencer: start/data/parity/stop, one-entry byte buffer, overrun, frame-end gap.
// Ports: clk, rst (async active-low), core strobes in, byte_if handshake, status out. TMR: UART_RX_TMR_EN.
module uart_rx_byte_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int GAP_BITS  = DEF_GAP_BITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Rx_Synch_i,
    input  logic               Bit_Synch_i,
    input  logic               RxBit_i,
    input  logic               AcqSig_i,
    input  logic               ParityEn_i,
    input  logic               ParityOdd_i,
    uart_rx_byte_ctrl_if.master byte_if,
    output logic               Overrun_o,
    output logic               FrameEnd_o,
    output logic [STATE_W-1:0] State_o,
    output logic [CNT_W-1:0]   BitCounter_o,
    output logic               TmrErr_o
);

    localparam int GW = $clog2(GAP_BITS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_BITS - 1);

    rx_state_e            state_q, st_nxt;
    logic [CNT_W-1:0]     cnt_q, cnt_nxt;
    logic                 complete, start_ok;

    logic [DATA_BITS-1:0] data_q;
    logic                 par_en_q, par_odd_q, perr_q;
    logic [7:0]           byte_q;
    logic                 valid_q, bperr_q, bferr_q, ovr_q;
    logic                 armed_q, fe_q;
    logic [GW-1:0]        gcnt_q;

`ifdef UART_RX_TMR_EN
    (* preserve *) logic [STATE_W-1:0] st_r0, st_r1, st_r2;
    (* preserve *) logic [CNT_W-1:0]   cnt_r0, cnt_r1, cnt_r2;
    logic [STATE_W-1:0] st_vote;
    logic [CNT_W-1:0]   cnt_vote;
    logic               st_err, cnt_err;

    tmr_voter #(.W(STATE_W)) u_st_vote (
        .a(st_r0), .b(st_r1), .c(st_r2), .y(st_vote), .err(st_err)
    );
    tmr_voter #(.W(CNT_W)) u_cnt_vote (
        .a(cnt_r0), .b(cnt_r1), .c(cnt_r2), .y(cnt_vote), .err(cnt_err)
    );

    // Replicas are all rewritten from the voted next value (scrubbing).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_r0  <= '0;
            st_r1  <= '0;
            st_r2  <= '0;
            cnt_r0 <= '0;
            cnt_r1 <= '0;
            cnt_r2 <= '0;
        end else begin
            st_r0  <= st_nxt;
            st_r1  <= st_nxt;
            st_r2  <= st_nxt;
            cnt_r0 <= cnt_nxt;
            cnt_r1 <= cnt_nxt;
            cnt_r2 <= cnt_nxt;
        end
    end

    assign state_q  = rx_state_e'(st_vote);
    assign cnt_q    = cnt_vote;
    assign TmrErr_o = st_err | cnt_err;
`else
    rx_state_e        st_r;
    logic [CNT_W-1:0] cnt_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_r  <= RX_IDLE;
            cnt_r <= '0;
        end else begin
            st_r  <= st_nxt;
            cnt_r <= cnt_nxt;
        end
    end

    assign state_q  = st_r;
    assign cnt_q    = cnt_r;
    assign TmrErr_o = 1'b0;
`endif

    always_comb begin
        st_nxt   = state_q;
        cnt_nxt  = cnt_q;
        complete = 1'b0;
        start_ok = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (Rx_Synch_i) st_nxt = RX_START;
            end
            RX_START: begin
                if (Bit_Synch_i) begin
                    if (RxBit_i) begin
                        st_nxt = RX_IDLE;
                    end else begin
                        st_nxt   = RX_DATA;
                        cnt_nxt  = '0;
                        start_ok = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (Bit_Synch_i) begin
                    if (cnt_q == LAST) begin
                        cnt_nxt = '0;
                        st_nxt  = par_en_q ? RX_PARITY : RX_STOP;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (Bit_Synch_i) st_nxt = RX_STOP;
            end
            RX_STOP: begin
                if (Bit_Synch_i) begin
                    st_nxt   = RX_IDLE;
                    complete = 1'b1;
                end
            end
            default: begin
                st_nxt  = RX_IDLE;
                cnt_nxt = '0;
            end
        endcase
    end

    // Character datapath; parity config is frozen for the whole character.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            if (start_ok) begin
                par_en_q  <= ParityEn_i;
                par_odd_q <= ParityOdd_i;
                perr_q    <= 1'b0;
            end
            // LSB first: after DATA_BITS shifts the first bit sits at bit 0.
            if (state_q == RX_DATA && Bit_Synch_i)
                data_q <= {RxBit_i, data_q[DATA_BITS-1:1]};
            if (state_q == RX_PARITY && Bit_Synch_i)
                perr_q <= ((^data_q) ^ RxBit_i) != par_odd_q;
        end
    end

    // One-entry buffer; a completing byte wins over a same-cycle accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_q  <= '0;
            valid_q <= 1'b0;
            bperr_q <= 1'b0;
            bferr_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (complete) begin
                if (!valid_q || byte_if.ByteReady_i) begin
                    byte_q  <= 8'(data_q);
                    bperr_q <= perr_q;
                    bferr_q <= ~RxBit_i;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && byte_if.ByteReady_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Idle gap: armed per byte, counts bit-times only in IDLE, fires once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q <= 1'b0;
            gcnt_q  <= '0;
            fe_q    <= 1'b0;
        end else begin
            fe_q <= 1'b0;
            if (complete) begin
                armed_q <= 1'b1;
                gcnt_q  <= '0;
            end else if (state_q == RX_IDLE) begin
                if (Rx_Synch_i) begin
                    gcnt_q <= '0;
                end else if (AcqSig_i && armed_q) begin
                    if (gcnt_q == GW'(GAP_BITS - 1)) begin
                        fe_q    <= 1'b1;
                        armed_q <= 1'b0;
                        gcnt_q  <= GW'(GAP_BITS);
                    end else begin
                        gcnt_q <= gcnt_q + 1'b1;
                    end
                end
            end
        end
    end

    assign byte_if.Byte_o      = byte_q;
    assign byte_if.ByteValid_o = valid_q;
    assign byte_if.ParityErr_o = bperr_q;
    assign byte_if.FrameErr_o  = bferr_q;
    assign Overrun_o           = ovr_q;
    assign FrameEnd_o          = fe_q;
    assign State_o             = state_q;
    assign BitCounter_o        = cnt_q;

endmodule
